// File: rtl/fifo_sc_if.sv
// Handshake bundle for fifo_sc: write port, read port, control and status.
// The master modport drives requests and data; the slave modport is the FIFO itself.
interface fifo_sc_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic             i_cg;
  logic             i_flush;
  logic [WIDTH-1:0] i_wdata;
  logic             i_wvalid;
  logic             o_wready;
  logic [WIDTH-1:0] o_rdata;
  logic             o_rvalid;
  logic             i_rready;
  logic [CntW-1:0]  o_nEntries;
  logic             o_almostFull;

  modport master (
    output i_cg, i_flush, i_wdata, i_wvalid, i_rready,
    input  o_wready, o_rdata, o_rvalid, o_nEntries, o_almostFull
  );

  modport slave (
    input  i_cg, i_flush, i_wdata, i_wvalid, i_rready,
    output o_wready, o_rdata, o_rvalid, o_nEntries, o_almostFull
  );
endinterface

// File: rtl/fifo_sc.sv
// Single-clock FIFO with clock gate, synchronous flush and almost-full flag.
// Optional macro FIFO_SC_BYPASS_EN adds a combinational write-to-read path while empty.
module fifo_sc #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AF_THRESH = DEPTH - 1
) (
  input logic       i_clk,
  input logic       i_rst,
  fifo_sc_if.slave  bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);
  localparam logic [CntW-1:0] AfCnt   = CntW'(AF_THRESH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic empty, full;
  logic do_write, do_read;
  logic do_store, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FullCnt);

  assign bus.o_wready     = !full && !bus.i_flush;
  assign bus.o_nEntries   = cnt_q;
  assign bus.o_almostFull = (cnt_q >= AfCnt);

  assign do_write = bus.o_wready && bus.i_wvalid;
  assign do_read  = bus.o_rvalid && bus.i_rready;

`ifdef FIFO_SC_BYPASS_EN
  logic pass_thru;

  // While empty the incoming word is presented directly; if it is consumed at once it never
  // touches storage, pointers or count.
  assign pass_thru    = empty && !bus.i_flush && bus.i_wvalid && bus.i_rready;
  assign bus.o_rvalid = empty ? (bus.i_wvalid && !bus.i_flush) : !bus.i_flush;
  assign bus.o_rdata  = empty ? bus.i_wdata : mem_q[rptr_q];
  assign do_store     = do_write && !pass_thru;
  assign do_pop       = do_read && !pass_thru;
`else
  assign bus.o_rvalid = !empty && !bus.i_flush;
  assign bus.o_rdata  = mem_q[rptr_q];
  assign do_store     = do_write;
  assign do_pop       = do_read;
`endif

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (bus.i_cg) begin
      if (bus.i_flush) begin
        wptr_d = '0;
        rptr_d = '0;
        cnt_d  = '0;
      end else begin
        if (do_store) wptr_d = wptr_q + PtrW'(1);
        if (do_pop)   rptr_d = rptr_q + PtrW'(1);
        if (do_store && !do_pop) begin
          cnt_d = cnt_q + CntW'(1);
        end else if (!do_store && do_pop) begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (bus.i_cg && do_store) begin
      mem_q[wptr_q] <= bus.i_wdata;
    end
  end

endmodule
